rcg_ctrl_rcc_mc: RTL and testbench



---
 rtl/rcg_ctrl_rcc_mc.sv | 188 ++++++++++++++++++
 tb/tb_rcg_ctrl_rcc_mc.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcg_ctrl_rcc_mc.sv
// rcg_ctrl_rcc_mc
//
// Multi-channel reset / clock-gate / divider-enable sequencer. Each channel
// runs its own OFF -> PRE -> ON -> DREQ -> OFF sequence from one source clock.
// Gated clocks are built outside the block from ch_cg_en.
//
// Ports
//   clk_in          source clock, rising edge
//   hgrst_n         hard reset, asynchronous, active-low
//   grst_n          soft global reset, synchronous, active-low
//   scan_mode       forces ch_cg_en/ch_div_en low and ch_rst_n high
//   gclk_div_en     divider enable qualifier
//   ch_req_on       per-channel on request (level)
//   ch_force_on     per-channel hold-on (level)
//   ch_force_off    per-channel force-off, highest priority
//   ch_hw_rst_req   per-channel re-reset pulse, honoured only while ON
//   ch_disable_ack  per-channel disable acknowledge
//   ch_cgen_dly     per-channel reset-hold cycles, channel i at [i*DLY_W +: DLY_W]
//   ch_to_err_clr   per-channel clear of the sticky timeout flag
//   ch_rst_n        module reset, active-low
//   ch_cg_en        clock-gate enable
//   ch_div_en       divider enable, DIV_SYNC cycles behind cg_en & gclk_div_en
//   ch_disable_req  disable request to module
//   ch_disable      module disabled indication
//   ch_state        per-channel state, 2 bits each (OFF=0 PRE=1 ON=2 DREQ=3)
//   ch_to_err       sticky disable-ACK timeout flag
//   busy            any channel in PRE or DREQ

module rcg_ctrl_rcc_mc #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned DIV_SYNC = 2,
    parameter int unsigned ACK_TO   = 255
) (
    input  logic                   clk_in,
    input  logic                   hgrst_n,
    input  logic                   grst_n,
    input  logic                   scan_mode,
    input  logic                   gclk_div_en,
    input  logic [NCH-1:0]         ch_req_on,
    input  logic [NCH-1:0]         ch_force_on,
    input  logic [NCH-1:0]         ch_force_off,
    input  logic [NCH-1:0]         ch_hw_rst_req,
    input  logic [NCH-1:0]         ch_disable_ack,
    input  logic [NCH*DLY_W-1:0]   ch_cgen_dly,
    input  logic [NCH-1:0]         ch_to_err_clr,
    output logic [NCH-1:0]         ch_rst_n,
    output logic [NCH-1:0]         ch_cg_en,
    output logic [NCH-1:0]         ch_div_en,
    output logic [NCH-1:0]         ch_disable_req,
    output logic [NCH-1:0]         ch_disable,
    output logic [2*NCH-1:0]       ch_state,
    output logic [NCH-1:0]         ch_to_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StPre  = 2'd1,
        StOn   = 2'd2,
        StDreq = 2'd3
    } ch_state_e;

    // ACK_TO = 0 still needs a 1-bit counter so the logic stays well formed.
    localparam int unsigned TCNT_W = (ACK_TO == 0) ? 1 : $clog2(ACK_TO + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = (ACK_TO == 0) ? '0 : TCNT_W'(ACK_TO - 1);

    logic [NCH-1:0] ch_busy;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e           state_q, state_d;
        logic [DLY_W-1:0]    cnt_q, cnt_d;
        logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
        logic                to_err_q, to_err_d;
        logic                to_set;
        logic                on_req;
        logic [DLY_W-1:0]    dly;
        logic                cg_int;
        logic                div_in;
        logic [DIV_SYNC-1:0] div_pipe_q;

        assign on_req = ch_req_on[i] | ch_force_on[i];
        assign dly    = ch_cgen_dly[i*DLY_W +: DLY_W];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tcnt_d  = tcnt_q;
            to_set  = 1'b0;
            if (ch_force_off[i] || !grst_n) begin
                state_d = StOff;
                cnt_d   = '0;
                tcnt_d  = '0;
            end else begin
                case (state_q)
                    StOff: begin
                        if (on_req) begin
                            state_d = StPre;
                            cnt_d   = dly;
                        end
                    end
                    StPre: begin
                        if (cnt_q == '0) begin
                            state_d = StOn;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    StOn: begin
                        if (ch_hw_rst_req[i]) begin
                            state_d = StPre;
                            cnt_d   = dly;
                        end else if (!on_req) begin
                            state_d = StDreq;
                            tcnt_d  = '0;
                        end
                    end
                    StDreq: begin
                        if (ch_disable_ack[i]) begin
                            state_d = StOff;
                        end else if (on_req) begin
                            state_d = StOn;
                        end else if ((ACK_TO != 0) && (tcnt_q == TCNT_LAST)) begin
                            state_d = StOff;
                            to_set  = 1'b1;
                        end else if (tcnt_q != TCNT_MAX) begin
                            // Saturate; only reachable when waiting forever.
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                    default: state_d = StOff;
                endcase
            end
        end

        // A timeout and a clear in the same cycle leave the flag set.
        assign to_err_d = to_set | (to_err_q & ~ch_to_err_clr[i]);

        always_ff @(posedge clk_in or negedge hgrst_n) begin
            if (!hgrst_n) begin
                state_q  <= StOff;
                cnt_q    <= '0;
                tcnt_q   <= '0;
                to_err_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                tcnt_q   <= tcnt_d;
                to_err_q <= to_err_d;
            end
        end

        assign cg_int = (state_q != StOff);
        assign div_in = cg_int & gclk_div_en & ~scan_mode;

        if (DIV_SYNC > 1) begin : g_pipe
            always_ff @(posedge clk_in or negedge hgrst_n) begin
                if (!hgrst_n) begin
                    div_pipe_q <= '0;
                end else begin
                    div_pipe_q <= {div_pipe_q[DIV_SYNC-2:0], div_in};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk_in or negedge hgrst_n) begin
                if (!hgrst_n) begin
                    div_pipe_q <= '0;
                end else begin
                    div_pipe_q <= div_in;
                end
            end
        end

        // Outputs decode straight from the state register; scan only masks them.
        assign ch_rst_n[i]       = state_q[1] | scan_mode;
        assign ch_cg_en[i]       = cg_int & ~scan_mode;
        assign ch_div_en[i]      = div_pipe_q[DIV_SYNC-1] & ~scan_mode;
        assign ch_disable_req[i] = (state_q == StDreq);
        assign ch_disable[i]     = (state_q == StOff);
        assign ch_state[2*i +: 2] = state_q;
        assign ch_to_err[i]      = to_err_q;
        assign ch_busy[i]        = (state_q == StPre) | (state_q == StDreq);
    end

    assign busy = |ch_busy;

endmodule

// File: tb/tb_rcg_ctrl_rcc_mc.sv
// tb_rcg_ctrl_rcc_mc
//
// Directed bench for rcg_ctrl_rcc_mc. A behavioural channel model (phase plus
// remaining PRE cycles / elapsed DREQ cycles) predicts every output each cycle;
// directed scenarios add literal expectations on cycle counts and states.

module tb_rcg_ctrl_rcc_mc;

    localparam int unsigned NCH      = 4;
    localparam int unsigned DLY_W    = 8;
    localparam int unsigned DIV_SYNC = 2;
    localparam int unsigned ACK_TO   = 255;

    localparam int P_OFF  = 0;
    localparam int P_PRE  = 1;
    localparam int P_ON   = 2;
    localparam int P_DREQ = 3;

    logic                 clk_in = 1'b0;
    logic                 hgrst_n;
    logic                 grst_n;
    logic                 scan_mode;
    logic                 gclk_div_en;
    logic [NCH-1:0]       ch_req_on;
    logic [NCH-1:0]       ch_force_on;
    logic [NCH-1:0]       ch_force_off;
    logic [NCH-1:0]       ch_hw_rst_req;
    logic [NCH-1:0]       ch_disable_ack;
    logic [NCH*DLY_W-1:0] ch_cgen_dly;
    logic [NCH-1:0]       ch_to_err_clr;
    logic [NCH-1:0]       ch_rst_n;
    logic [NCH-1:0]       ch_cg_en;
    logic [NCH-1:0]       ch_div_en;
    logic [NCH-1:0]       ch_disable_req;
    logic [NCH-1:0]       ch_disable;
    logic [2*NCH-1:0]     ch_state;
    logic [NCH-1:0]       ch_to_err;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    rcg_ctrl_rcc_mc #(
        .NCH      (NCH),
        .DLY_W    (DLY_W),
        .DIV_SYNC (DIV_SYNC),
        .ACK_TO   (ACK_TO)
    ) dut (
        .clk_in         (clk_in),
        .hgrst_n        (hgrst_n),
        .grst_n         (grst_n),
        .scan_mode      (scan_mode),
        .gclk_div_en    (gclk_div_en),
        .ch_req_on      (ch_req_on),
        .ch_force_on    (ch_force_on),
        .ch_force_off   (ch_force_off),
        .ch_hw_rst_req  (ch_hw_rst_req),
        .ch_disable_ack (ch_disable_ack),
        .ch_cgen_dly    (ch_cgen_dly),
        .ch_to_err_clr  (ch_to_err_clr),
        .ch_rst_n       (ch_rst_n),
        .ch_cg_en       (ch_cg_en),
        .ch_div_en      (ch_div_en),
        .ch_disable_req (ch_disable_req),
        .ch_disable     (ch_disable),
        .ch_state       (ch_state),
        .ch_to_err      (ch_to_err),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int phase;
        int left;    // PRE cycles still to spend, including the current one
        int waited;  // DREQ cycles spent, including the current one
        bit err;
    } ch_model_t;

    ch_model_t      m_ch   [NCH];
    logic [NCH-1:0] m_past [DIV_SYNC];

    function automatic ch_model_t step_ch(ch_model_t c, bit on, bit foff, bit grst, bit hw,
                                          bit ack, bit clr, int d);
        ch_model_t n = c;
        bit tmo = 1'b0;
        if (foff || !grst) begin
            n.phase  = P_OFF;
            n.left   = 0;
            n.waited = 0;
        end else if (c.phase == P_OFF) begin
            if (on) begin
                n.phase = P_PRE;
                n.left  = d + 1;
            end
        end else if (c.phase == P_PRE) begin
            n.left = c.left - 1;
            if (c.left <= 1) n.phase = P_ON;
        end else if (c.phase == P_ON) begin
            if (hw) begin
                n.phase = P_PRE;
                n.left  = d + 1;
            end else if (!on) begin
                n.phase  = P_DREQ;
                n.waited = 1;
            end
        end else begin
            if (ack) n.phase = P_OFF;
            else if (on) n.phase = P_ON;
            else if (ACK_TO != 0 && c.waited >= int'(ACK_TO)) begin
                n.phase = P_OFF;
                tmo     = 1'b1;
            end else n.waited = c.waited + 1;
        end
        n.err = tmo | (c.err & ~clr);
        return n;
    endfunction

    function automatic logic [NCH-1:0] model_cg_raw();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_ch[i].phase != P_OFF);
        return v;
    endfunction

    always @(posedge clk_in or negedge hgrst_n) begin
        if (!hgrst_n) begin
            for (int i = 0; i < NCH; i++) m_ch[i] <= '{P_OFF, 0, 0, 1'b0};
            for (int k = 0; k < DIV_SYNC; k++) m_past[k] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                m_ch[i] <= step_ch(m_ch[i], ch_req_on[i] | ch_force_on[i], ch_force_off[i],
                                   grst_n, ch_hw_rst_req[i], ch_disable_ack[i],
                                   ch_to_err_clr[i], int'(ch_cgen_dly[i*DLY_W +: DLY_W]));
            end
            m_past[0] <= model_cg_raw() & {NCH{gclk_div_en}} & ~{NCH{scan_mode}};
            for (int k = 1; k < DIV_SYNC; k++) m_past[k] <= m_past[k-1];
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk_in) begin
        logic [NCH-1:0]   e_rst, e_cg, e_dis, e_dreq, e_err;
        logic [2*NCH-1:0] e_st;
        logic             e_busy;
        e_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            e_rst[i]      = (m_ch[i].phase >= P_ON) | scan_mode;
            e_cg[i]       = (m_ch[i].phase != P_OFF) & ~scan_mode;
            e_dis[i]      = (m_ch[i].phase == P_OFF);
            e_dreq[i]     = (m_ch[i].phase == P_DREQ);
            e_err[i]      = m_ch[i].err;
            e_st[2*i +: 2] = 2'(m_ch[i].phase);
            if (m_ch[i].phase == P_PRE || m_ch[i].phase == P_DREQ) e_busy = 1'b1;
        end
        check("m_rst_n", 64'(ch_rst_n), 64'(e_rst));
        check("m_cg_en", 64'(ch_cg_en), 64'(e_cg));
        check("m_div_en", 64'(ch_div_en), 64'(m_past[DIV_SYNC-1] & ~{NCH{scan_mode}}));
        check("m_disable", 64'(ch_disable), 64'(e_dis));
        check("m_disable_req", 64'(ch_disable_req), 64'(e_dreq));
        check("m_state", 64'(ch_state), 64'(e_st));
        check("m_to_err", 64'(ch_to_err), 64'(e_err));
        check("m_busy", 64'(busy), 64'(e_busy));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_state(input logic [2*NCH-1:0] want, input string name);
        int n = 0;
        while (ch_state !== want && n < 50) begin
            tick();
            n++;
        end
        check(name, 64'(ch_state), 64'(want));
    endtask

    initial begin
        int t_cg, t_div, t_rst, pre_n, dq;
        hgrst_n        = 1'b0;
        grst_n         = 1'b1;
        scan_mode      = 1'b0;
        gclk_div_en    = 1'b1;
        ch_req_on      = '0;
        ch_force_on    = '0;
        ch_force_off   = '0;
        ch_hw_rst_req  = '0;
        ch_disable_ack = '0;
        ch_cgen_dly    = '0;
        ch_to_err_clr  = '0;

        repeat (3) tick();
        check("rst_state", 64'(ch_state), 64'h0);
        check("rst_disable", 64'(ch_disable), 64'hF);
        check("rst_rst_n", 64'(ch_rst_n), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        hgrst_n = 1'b1;
        tick();

        // ch0: dly 3 -> 4 PRE cycles, div_en 2 after cg_en, rst_n at cycle 5
        ch_cgen_dly[7:0] = 8'd3;
        ch_req_on[0]     = 1'b1;
        t_cg = -1; t_div = -1; t_rst = -1; pre_n = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ch_cg_en[0] && t_cg < 0) t_cg = c;
            if (ch_div_en[0] && t_div < 0) t_div = c;
            if (ch_rst_n[0] && t_rst < 0) t_rst = c;
            if (ch_state[1:0] == 2'd1) pre_n++;
        end
        check("ch0_pre_cycles", 64'(pre_n), 64'd4);
        check("ch0_cg_rise", 64'(t_cg), 64'd1);
        check("ch0_div_rise", 64'(t_div), 64'd3);
        check("ch0_rst_rise", 64'(t_rst), 64'd5);

        // ch1: disable handshake acked on the 5th DREQ cycle
        ch_req_on[1] = 1'b1;
        wait_state(8'h0A, "ch1_on");
        ch_req_on[1] = 1'b0;
        dq = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ch_state[3:2] != 2'd3) break;
            dq++;
            if (dq == 5) ch_disable_ack[1] = 1'b1;
        end
        ch_disable_ack[1] = 1'b0;
        check("ch1_dreq_cycles", 64'(dq), 64'd5);
        check("ch1_disable", 64'(ch_disable[1]), 64'd1);
        check("ch1_no_to_err", 64'(ch_to_err[1]), 64'd0);

        // ch2: no ack -> timeout after exactly ACK_TO DREQ cycles
        ch_req_on[2] = 1'b1;
        wait_state(8'h22, "ch2_on");
        ch_req_on[2] = 1'b0;
        dq = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (ch_state[5:4] != 2'd3) break;
            dq++;
        end
        check("ch2_dreq_cycles", 64'(dq), 64'd255);
        check("ch2_off", 64'(ch_state[5:4]), 64'd0);
        check("ch2_to_err_set", 64'(ch_to_err[2]), 64'd1);
        tick();
        check("ch2_to_err_sticky", 64'(ch_to_err[2]), 64'd1);
        ch_to_err_clr[2] = 1'b1;
        tick();
        ch_to_err_clr[2] = 1'b0;
        check("ch2_to_err_clr", 64'(ch_to_err[2]), 64'd0);

        // ch3: hw_rst_req with dly 0 -> one PRE cycle, others untouched
        ch_req_on[3] = 1'b1;
        wait_state(8'h82, "ch3_on");
        ch_hw_rst_req[3] = 1'b1;
        tick();
        ch_hw_rst_req[3] = 1'b0;
        check("ch3_hwrst_state", 64'(ch_state), 64'h42);
        check("ch3_hwrst_rst_n", 64'(ch_rst_n), 64'b0001);
        check("ch3_hwrst_cg", 64'(ch_cg_en), 64'b1001);
        tick();
        check("ch3_back_on", 64'(ch_state), 64'h82);

        // hw_rst_req outside ON is ignored
        ch_hw_rst_req[1] = 1'b1;
        tick();
        ch_hw_rst_req[1] = 1'b0;
        check("hwrst_off_ignored", 64'(ch_state[3:2]), 64'd0);

        // all channels on, one-cycle grst_n
        ch_req_on = 4'hF;
        wait_state(8'hAA, "all_on");
        grst_n = 1'b0;
        tick();
        grst_n = 1'b1;
        check("grst_all_off", 64'(ch_state), 64'h00);
        tick();
        check("grst_then_pre", 64'(ch_state), 64'h55);
        wait_state(8'hAA, "all_on_again");

        // force_off beats force_on
        ch_force_on[0]  = 1'b1;
        ch_force_off[0] = 1'b1;
        tick();
        check("force_off_win", 64'(ch_state), 64'hA8);
        tick();
        check("force_off_hold", 64'(ch_state[1:0]), 64'd0);
        ch_force_off[0] = 1'b0;
        ch_force_on[0]  = 1'b0;
        wait_state(8'hAA, "ch0_recover");

        // DREQ abort by on_i, then ack and on together -> OFF then PRE
        ch_req_on[1] = 1'b0;
        tick();
        ch_req_on[1] = 1'b1;
        tick();
        check("dreq_abort", 64'(ch_state[3:2]), 64'd2);
        ch_req_on[1] = 1'b0;
        tick();
        ch_req_on[1]      = 1'b1;
        ch_disable_ack[1] = 1'b1;
        tick();
        ch_disable_ack[1] = 1'b0;
        check("ack_on_off", 64'(ch_state[3:2]), 64'd0);
        tick();
        check("ack_on_pre", 64'(ch_state[3:2]), 64'd1);
        wait_state(8'hAA, "ch1_recover");

        // gclk_div_en toggling
        gclk_div_en = 1'b0;
        repeat (3) tick();
        check("div_gated", 64'(ch_div_en), 64'h0);
        gclk_div_en = 1'b1;
        repeat (3) tick();

        // scan mode masks outputs but not the FSMs
        scan_mode = 1'b1;
        #1;
        check("scan_cg", 64'(ch_cg_en), 64'h0);
        check("scan_div", 64'(ch_div_en), 64'h0);
        check("scan_rst_n", 64'(ch_rst_n), 64'hF);
        repeat (3) tick();
        check("scan_state", 64'(ch_state), 64'hAA);
        scan_mode = 1'b0;
        #1;
        check("scan_exit_cg", 64'(ch_cg_en), 64'hF);
        repeat (4) tick();
        check("scan_exit_div", 64'(ch_div_en), 64'hF);

        ch_req_on = '0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
